// File: rtl/calc_pkg.sv
// calc_pkg: shared sequencer state encoding and data width for the calculator front end
package calc_pkg;
   localparam int DATA_W = 8;
   typedef enum logic [1:0] {WAIT_A = 2'd0, WAIT_B = 2'd1, WAIT_OP = 2'd2, DONE = 2'd3} state_t;
endpackage

// File: rtl/operand_loader_if.sv
// operand_loader_if: switch/button inputs and register-bank load bus of the operand loader
interface operand_loader_if;
   import calc_pkg::*;
   logic [DATA_W-1:0] in_SW;
   logic              in_BTN_ENTER;
   logic              in_BTN_CLEAR;
   logic [DATA_W-1:0] out_D;
   logic              out_EN_A;
   logic              out_EN_B;
   logic              out_EN_OP;
   logic              out_GO;
   logic [1:0]        out_STATE;
   modport master (
      input  in_SW, in_BTN_ENTER, in_BTN_CLEAR,
      output out_D, out_EN_A, out_EN_B, out_EN_OP, out_GO, out_STATE
   );
   modport slave (
      output in_SW, in_BTN_ENTER, in_BTN_CLEAR,
      input  out_D, out_EN_A, out_EN_B, out_EN_OP, out_GO, out_STATE
   );
endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: synchronise a raw button, accept a level after DEBOUNCE_CYCLES steady cycles, pulse on press
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 24
) (
   input  logic in_CLK,
   input  logic in_RST,
   input  logic in_BTN,
   output logic out_PULSE
);
   logic             sync1, s, stable, stable_q;
   logic [CNT_W-1:0] cnt;
   logic             hit;
   assign hit = cnt == CNT_W'(DEBOUNCE_CYCLES - 1);
   always_ff @(posedge in_CLK or posedge in_RST) begin
      if (in_RST) begin
         sync1     <= 1'b0;
         s         <= 1'b0;
         stable    <= 1'b0;
         stable_q  <= 1'b0;
         cnt       <= '0;
         out_PULSE <= 1'b0;
      end else begin
         sync1     <= in_BTN;
         s         <= sync1;
         stable_q  <= stable;
         out_PULSE <= stable & ~stable_q;
         if (s == stable) cnt <= '0;
         else if (hit) begin
            stable <= s;
            cnt    <= '0;
         end else cnt <= cnt + CNT_W'(1);
      end
   end
endmodule

// File: rtl/operand_loader.sv
// operand_loader: debounced ENTER/CLEAR sequencer loading operand A, operand B and opcode banks, then pulsing GO
module operand_loader
   import calc_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 24
) (
   input logic               in_CLK,
   input logic               in_RST,
   operand_loader_if.master  bus
);
   logic              enter, clear, load;
   state_t            state, state_n;
   logic [DATA_W-1:0] d, d_n;
   logic              en_a, en_b, en_op, go, en_a_n, en_b_n, en_op_n;
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_enter (
      .in_CLK(in_CLK), .in_RST(in_RST), .in_BTN(bus.in_BTN_ENTER), .out_PULSE(enter)
   );
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_clear (
      .in_CLK(in_CLK), .in_RST(in_RST), .in_BTN(bus.in_BTN_CLEAR), .out_PULSE(clear)
   );
   always_ff @(posedge in_CLK or posedge in_RST) begin
      if (in_RST) begin
         state <= WAIT_A;
         d     <= '0;
         en_a  <= 1'b0;
         en_b  <= 1'b0;
         en_op <= 1'b0;
         go    <= 1'b0;
      end else begin
         state <= state_n;
         d     <= d_n;
         en_a  <= en_a_n;
         en_b  <= en_b_n;
         en_op <= en_op_n;
         go    <= en_op;
      end
   end
   // clear overrides a coincident enter; DONE chains straight into a new A load
   always_comb begin
      load    = enter & ~clear;
      state_n = clear ? WAIT_A :
                !enter ? state :
                (state == WAIT_A || state == DONE) ? WAIT_B :
                state == WAIT_B ? WAIT_OP : DONE;
      en_a_n  = load & (state == WAIT_A || state == DONE);
      en_b_n  = load & (state == WAIT_B);
      en_op_n = load & (state == WAIT_OP);
      d_n     = load ? bus.in_SW : d;
   end
   assign bus.out_D     = d;
   assign bus.out_EN_A  = en_a;
   assign bus.out_EN_B  = en_b;
   assign bus.out_EN_OP = en_op;
   assign bus.out_GO    = go;
   assign bus.out_STATE = state;
endmodule
